exe_mdu: RTL
============

# exe_mdu

Multi-cycle multiply/divide unit for the RV32M/RV64M execute stage. It sits beside the single-cycle execute datapath and accepts `INST_TYPE_R_M` operations with `funct7 == 7'b0000001`. It runs them over several cycles and raises a stall to `pipe_ctrl` until the result is ready for `exe_mem`. It replaces the combinational M-path with a parametrised, timing-friendly implementation.

## Interface
Parameters:
- `XLEN`, 32: operand and result width; legal values are 32 and 64.
- `MUL_LATENCY`, 2: cycles from accepted start to `done_o` for MUL*; legal range 1..4.

Ports:
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  launch request; sampled only in IDLE.
- `funct3_i`  in  3  M-op select: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- `op1_i`, `op2_i`  in  XLEN  rs1 and rs2 values.
- `reg_waddr_i`  in  5  destination register.
- `flush_i`  in  1  pipeline flush; aborts any operation in progress.
- `stall_o`  out  1  hold request to `pipe_ctrl`.
- `done_o`  out  1  one-cycle pulse; the result is valid in this cycle.
- `result_o`  out  XLEN  result, held until the next accepted start.
- `reg_waddr_o`  out  5  destination register, latched at start.
- `reg_we_o`  out  1  equals `done_o`.
- `unsupported_o`  out  1  pulses with `done_o` for DIV* ops when the divider is compiled out.

## Operation
- The FSM has four states: IDLE, MUL, DIV, DONE.
- Reset: state = IDLE. `done_o`, `reg_we_o` and `unsupported_o` are 0. `result_o` is 0 and `reg_waddr_o` is 0. Internal counters are cleared.
- IDLE: when `start_i` = 1 and `flush_i` = 0:
  - latch operands, `funct3_i` and `reg_waddr_i`;
  - a MUL* op goes to MUL;
  - a DIV* op goes to DIV, unless it is a special case, which goes to DONE.
- MUL:
  - The 2·XLEN product is formed from sign-extended (XLEN+1)-bit operands: MULHSU sign-extends only `op1`, MULHU sign-extends neither.
  - The product is delayed through a `MUL_LATENCY`-deep register chain, then the FSM goes to DONE.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- DIV: restoring radix-2 division on operand magnitudes.
  - The iteration counter starts at XLEN−1 and counts down.
  - One quotient bit is produced per cycle; after the last iteration the FSM goes to DONE.
  - Sign fixup happens in DONE: the quotient is negated if the operand signs differ (signed ops only), and the remainder takes the sign of the dividend.
- Special cases go directly to DONE with no iteration:
  - Divisor = 0: quotient = all-ones, remainder = `op1`.
  - Signed overflow (`op1` = most-negative value, `op2` = −1): quotient = `op1`, remainder = 0.
- DONE: `result_o` is registered, `done_o` = 1 for one cycle, then the FSM returns to IDLE.
- `start_i` outside IDLE is ignored. The integrated pipeline guarantees this never happens, because the stall holds the instruction.
- `flush_i` in any state: next state = IDLE and `done_o` does not assert. `result_o` keeps its old value. Flush has priority over `start_i` and over DONE.
- Reset mid-operation: the block behaves exactly as at power-up reset.

## Timing
- Latency, counted from the start cycle to the `done_o` cycle:
  - MUL*: `MUL_LATENCY` + 1.
  - DIV* (normal): XLEN + 1, so 33 cycles at XLEN = 32.
  - DIV* special cases: 1.
- `stall_o` is combinational:
  - 1 in IDLE when `start_i` = 1 and `flush_i` = 0;
  - 1 in MUL and DIV;
  - 0 in DONE and in IDLE without a start.
- The instruction advances in the cycle `done_o` = 1, and a back-to-back start is accepted in the cycle after `done_o`.
- No combinational path runs from `op1_i`/`op2_i` to `result_o`.

## Configuration
- Macro: `MDU_DIV_EN`.
- Defined: the divider FSM path and special-case logic are present as specified above.
- Undefined:
  - no divider hardware;
  - DIV* ops go from IDLE to DONE with `result_o` = 0 and `unsupported_o` = 1, with `done_o` after 1 cycle;
  - MUL* behaviour is unchanged.

## Structure
- `defines.v` additions:
  - `INST_MUL` through `INST_REMU` funct3 codes;
  - `INST_M_F` (funct7 = 7'b0000001);
  - FSM state encodings `MDU_IDLE`, `MDU_MUL`, `MDU_DIV` and `MDU_DONE`.
- Sub-module `mdu_div_iter` holds the remainder/quotient shift registers, the counter and the subtract/restore step. It is instantiated only under `MDU_DIV_EN`.
- The multiply path and the FSM are kept in the top level.

## Test plan
- MUL: `op1` = 7, `op2` = −3 (`0xFFFFFFFD`), `MUL_LATENCY` = 2 → `done_o` at cycle 3, `result_o` = `0xFFFFFFEB`. MULHU with `0xFFFFFFFF`×`0xFFFFFFFF` → `0xFFFFFFFE`.
- DIV: −20 / 3 → `done_o` at cycle 33, `result_o` = `0xFFFFFFFA`. REM −20 % 3 → `0xFFFFFFFE`. DIVU `0x80000000` / 2 → `0x40000000`.
- Special cases:
  - DIV 5 / 0 → `0xFFFFFFFF` at cycle 1;
  - REMU 5 % 0 → 5;
  - DIV `0x80000000` / −1 → `0x80000000`, and REM gives 0.
- Flush: assert `flush_i` at cycle 10 of a DIV → `stall_o` = 0 on the next cycle, no `done_o`, and `result_o` keeps its prior value.
- Back-to-back and ignored start: a MUL then a DIV start in the cycle after `done_o` → both complete. `start_i` held during DIV → no restart.
- Config: build without `MDU_DIV_EN`, issue DIV 9 / 3 → `done_o` and `unsupported_o` after 1 cycle with `result_o` = 0. MUL 6×7 → 42.

Source files
------------

// File: rtl/exe_mdu_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: M-extension
// funct3/funct7 codes and the MDU state encoding.
package exe_mdu_pkg;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  localparam logic [6:0] INST_M_F = 7'b0000001;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  // funct3[2] separates the divide/remainder group from the multiplies.
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Restoring radix-2 divider core working on unsigned magnitudes: one quotient
// bit per step, counter loaded with XLEN-1 and counting down to the last step.
module mdu_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            last_o
);

  localparam int CW = $clog2(XLEN);

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Partial remainder stays below the divisor, so bit XLEN of diff is the borrow.
  assign shifted = {rem, quo[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
      quo <= '0;
      rem <= '0;
      dvs <= '0;
    end else if (load_i) begin
      cnt <= CW'(XLEN - 1);
      quo <= dividend_i;
      rem <= '0;
      dvs <= divisor_i;
    end else if (step_i) begin
      cnt <= cnt - 1'b1;
      if (!diff[XLEN]) begin
        rem <= diff[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end else begin
        rem <= shifted[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b0};
      end
    end
  end

  assign quotient_o  = quo;
  assign remainder_o = rem;
  assign last_o      = (cnt == '0);

endmodule

// File: rtl/exe_mdu.sv
// Multi-cycle RV32M/RV64M multiply/divide unit with pipeline stall handshake.
// Define MDU_DIV_EN to build the divider; otherwise DIV* ops report unsupported.
module exe_mdu
  import exe_mdu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      reg_waddr_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      reg_waddr_o,
  output logic            reg_we_o,
  output logic            unsupported_o,
  output logic [1:0]      dbg_state_o
);

  // Handshake: a start is taken only in IDLE without flush; stall_o stays high
  // until the DONE cycle, in which done_o/reg_we_o pulse and the instruction advances.
  mdu_state_e      state;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] op1_q;
  logic [XLEN-1:0] op2_q;
  logic [XLEN-1:0] result_q;
  logic [2:0]      mul_cnt;
  logic [XLEN-1:0] mul_pipe [MUL_LATENCY];
  logic            start_ok;
  logic            div_skip;
  logic            div_last;
  logic [XLEN-1:0] div_val;
  logic [XLEN-1:0] done_val;

  assign start_ok = (state == MDU_IDLE) && start_i && !flush_i;
  assign stall_o  = start_ok || (state == MDU_MUL) || (state == MDU_DIV);
  assign done_o   = (state == MDU_DONE) && !flush_i;
  assign reg_we_o = done_o;
  assign dbg_state_o = state;

  // Sign-extending to 2*XLEN gives the same low 2*XLEN product bits as the
  // (XLEN+1)-bit signed multiply.
  logic            sx1, sx2;
  logic [2*XLEN-1:0] ea, eb, prod;
  logic [XLEN-1:0] mul_sel;
  assign sx1     = (funct3_q != INST_MULHU);
  assign sx2     = (funct3_q == INST_MUL) || (funct3_q == INST_MULH);
  assign ea      = {{XLEN{sx1 & op1_q[XLEN-1]}}, op1_q};
  assign eb      = {{XLEN{sx2 & op2_q[XLEN-1]}}, op2_q};
  assign prod    = ea * eb;
  assign mul_sel = (funct3_q == INST_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

`ifdef MDU_DIV_EN
  logic            in_signed, in_zero, in_ovf;
  logic [XLEN-1:0] abs1, abs2, quo, rem, q_fix, r_fix;
  logic            special_q, qneg_q, rneg_q;

  assign in_signed = !funct3_i[0];
  assign in_zero   = (op2_i == '0);
  assign in_ovf    = in_signed && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
  assign abs1      = (in_signed && op1_i[XLEN-1]) ? -op1_i : op1_i;
  assign abs2      = (in_signed && op2_i[XLEN-1]) ? -op2_i : op2_i;
  assign div_skip  = in_zero || in_ovf;

  mdu_div_iter #(.XLEN(XLEN)) u_div_iter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (start_ok && is_div_op(funct3_i)),
    .step_i      (state == MDU_DIV),
    .dividend_i  (abs1),
    .divisor_i   (abs2),
    .quotient_o  (quo),
    .remainder_o (rem),
    .last_o      (div_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      special_q <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
    end else if (start_ok) begin
      special_q <= div_skip;
      qneg_q    <= in_signed && (op1_i[XLEN-1] ^ op2_i[XLEN-1]);
      rneg_q    <= in_signed && op1_i[XLEN-1];
    end
  end

  always_comb begin
    q_fix = qneg_q ? -quo : quo;
    r_fix = rneg_q ? -rem : rem;
    if (special_q) begin
      if (op2_q == '0) begin
        q_fix = '1;
        r_fix = op1_q;
      end else begin
        q_fix = op1_q;
        r_fix = '0;
      end
    end
    div_val = funct3_q[1] ? r_fix : q_fix;
  end

  assign unsupported_o = 1'b0;
`else
  assign div_skip      = 1'b1;
  assign div_last      = 1'b1;
  assign div_val       = '0;
  assign unsupported_o = done_o && is_div_op(funct3_q);
`endif

  assign done_val = is_div_op(funct3_q) ? div_val : mul_pipe[MUL_LATENCY-1];
  // The new result is visible only while done_o is high; a flushed DONE leaves it untouched.
  assign result_o = done_o ? done_val : result_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= MDU_IDLE;
      funct3_q    <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      reg_waddr_o <= '0;
      result_q    <= '0;
      mul_cnt     <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) mul_pipe[i] <= '0;
    end else begin
      if (state == MDU_MUL) begin
        mul_pipe[0] <= mul_sel;
        for (int i = 1; i < MUL_LATENCY; i++) mul_pipe[i] <= mul_pipe[i-1];
      end
      if (flush_i) begin
        state <= MDU_IDLE;
      end else begin
        case (state)
          MDU_IDLE: if (start_i) begin
            funct3_q    <= funct3_i;
            op1_q       <= op1_i;
            op2_q       <= op2_i;
            reg_waddr_o <= reg_waddr_i;
            mul_cnt     <= 3'(MUL_LATENCY - 1);
            if (!is_div_op(funct3_i)) state <= MDU_MUL;
            else if (div_skip)        state <= MDU_DONE;
            else                      state <= MDU_DIV;
          end
          MDU_MUL: begin
            if (mul_cnt == '0) state <= MDU_DONE;
            else               mul_cnt <= mul_cnt - 1'b1;
          end
          MDU_DIV: if (div_last) state <= MDU_DONE;
          MDU_DONE: begin
            result_q <= done_val;
            state    <= MDU_IDLE;
          end
          default: state <= MDU_IDLE;
        endcase
      end
    end
  end

endmodule
